// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the fifo and the controller that feeds it:
//   default data width / depth, the write-FSM state encoding and the
//   helper that sizes an occupancy counter able to hold 0..depth.
package fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    TURN  = 2'd2
  } wr_state_e;

  // Width of a counter that must represent every value from 0 to depth
  // inclusive (depth is a power of two, so one extra bit is needed).
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. The search starts one position after
//   the previously granted producer and wraps, so the last winner has the
//   lowest priority.
// Ports:
//   req   - request vector, one bit per producer
//   last  - index of the previously granted producer
//   grant - one-hot pick (all zero when no request)
//   valid - at least one request was found
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment so no path leaves it unassigned (no latch).
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last) + off) % NREQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl
//   Shares the write port of an attached fifo among NREQ producers using
//   round-robin bursts of up to MAX_BURST words, schedules its read port
//   for one consumer and tracks occupancy so neither side over/underflows.
//   The attached fifo runs on the same clock and the same reset.
// Ports:
//   inp_clk            - the only clock
//   reset              - asynchronous, active-high
//   req/req_d/req_last - producer requests, data slices, end-of-burst marks
//   gnt                - registered one-hot grant
//   ack                - word of producer i accepted this cycle
//   write_flg, inp_d   - fifo write port
//   rd_req             - consumer wants a word
//   read_flg           - fifo read strobe
//   rd_valid           - fifo out_d holds a valid word this cycle
//   level, full, empty - registered occupancy and its decodes
module fifo_arb_ctrl
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = FIFO_DW,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int MAX_BURST = 4
) (
  input  logic                          inp_clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*DW-1:0]            req_d,
  input  logic [NREQ-1:0]               req_last,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               ack,
  output logic                          write_flg,
  output logic [DW-1:0]                 inp_d,
  input  logic                          rd_req,
  output logic                          read_flg,
  output logic                          rd_valid,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          full,
  output logic                          empty
);

  localparam int LW = level_width(DEPTH);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  wr_state_e       state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt, bcnt_inc;
  logic [NREQ-1:0] arb_gnt;
  logic            arb_valid;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (req),
    .last  (last),
    .grant (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx = IW'(i);
    end
  end

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign bcnt_inc = bcnt + BW'(1);

  // Output decode. While granted, `last` holds the granted index, so it
  // selects the data slice and the end-of-burst bit. full/empty come from
  // the registered level, so a same-cycle read cannot make room for a write
  // and a same-cycle write cannot feed a read.
  always_comb begin
    ack = '0;
    if (state == BURST) ack = req & gnt & {NREQ{~full}};
    write_flg = |ack;
    inp_d     = req_d[int'(last)*DW +: DW];
    read_flg  = rd_req & ~empty;
  end

  // Next-state logic. A full fifo simply withholds ack, so the burst stalls
  // with gnt held rather than ending.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          gnt_nxt   = arb_gnt;
          last_nxt  = arb_idx;
          bcnt_nxt  = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (write_flg) bcnt_nxt = bcnt_inc;
        if (!req[last] ||
            (write_flg && (req_last[last] || bcnt_inc == BW'(MAX_BURST)))) begin
          gnt_nxt   = '0;
          state_nxt = TURN;
        end
      end
      TURN:    state_nxt = IDLE;
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample pre-edge values regardless of statement order.
  always_ff @(posedge inp_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= IW'(NREQ - 1);
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_ff @(posedge inp_clk or posedge reset) begin
    if (reset) begin
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= read_flg;
      case ({write_flg, read_flg})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl
//   Directed bench for fifo_arb_ctrl with a small behavioural fifo attached
//   so read data order can be checked. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge.
module tb_fifo_arb_ctrl;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int DEPTH = 16;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, req_last, gnt, ack;
  logic [NREQ*DW-1:0] req_d;
  logic              write_flg, rd_req, read_flg, rd_valid, full, empty;
  logic [DW-1:0]     inp_d;
  logic [4:0]        level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_arb_ctrl #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .inp_clk   (clk),
    .reset     (reset),
    .req       (req),
    .req_d     (req_d),
    .req_last  (req_last),
    .gnt       (gnt),
    .ack       (ack),
    .write_flg (write_flg),
    .inp_d     (inp_d),
    .rd_req    (rd_req),
    .read_flg  (read_flg),
    .rd_valid  (rd_valid),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Behavioural fifo driven by the controller's strobes.
  logic [DW-1:0] mem [DEPTH];
  logic [3:0]    wp, rp;
  logic [DW-1:0] out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      out_d <= '0;
    end else begin
      if (write_flg) begin
        mem[wp] <= inp_d;
        wp      <= wp + 4'd1;
      end
      if (read_flg) begin
        out_d <= mem[rp];
        rp    <= rp + 4'd1;
      end
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [4:0] level;
  } rr_vec_t;

  rr_vec_t vt [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    req_last = '0;
    req_d    = '0;
    rd_req   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // Producer p sends n words base, base+1, ... marking the last one.
  task automatic write_words(input int p, input int n, input logic [7:0] base);
    int w = 0;
    int budget = 0;
    req = '0;
    req[p] = 1'b1;
    while (w < n && budget < 100) begin
      req_d = '0;
      req_d[p*8 +: 8] = base + 8'(w);
      req_last = '0;
      req_last[p] = (w == n - 1);
      @(negedge clk);
      if (ack[p]) w++;
      tick();
      budget++;
    end
    check("write_words_count", w, n);
    req      = '0;
    req_last = '0;
  endtask

  // Reads n words; expects out_d = base, base+1, ... one cycle after each read.
  task automatic read_drain(input int n, input logic [7:0] base);
    rd_req = 1'b1;
    for (int j = 0; j < n + 2; j++) begin
      @(negedge clk);
      check("rd_read_flg", read_flg, (j < n));
      check("rd_valid", rd_valid, (j >= 1 && j <= n));
      if (j >= 1 && j <= n) check("rd_out_d", out_d, base + j - 1);
      if (j <= n) check("rd_level", level, n - j);
      tick();
    end
    rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] exp_ack;
    int w_exp;
    int gi;
    int b;

    vt[0]  = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd0};
    vt[1]  = '{4'hF, 4'h0, 4'h1, 4'h1, 5'd0};
    vt[2]  = '{4'hF, 4'hF, 4'h1, 4'h1, 5'd1};
    vt[3]  = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd2};
    vt[4]  = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd2};
    vt[5]  = '{4'hF, 4'h0, 4'h2, 4'h2, 5'd2};
    vt[6]  = '{4'hF, 4'hF, 4'h2, 4'h2, 5'd3};
    vt[7]  = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd4};
    vt[8]  = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd4};
    vt[9]  = '{4'hF, 4'h0, 4'h4, 4'h4, 5'd4};
    vt[10] = '{4'hF, 4'hF, 4'h4, 4'h4, 5'd5};
    vt[11] = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd6};
    vt[12] = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd6};
    vt[13] = '{4'hF, 4'h0, 4'h8, 4'h8, 5'd6};
    vt[14] = '{4'hF, 4'hF, 4'h8, 4'h8, 5'd7};
    vt[15] = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd8};
    vt[16] = '{4'hF, 4'h0, 4'h0, 4'h0, 5'd8};
    vt[17] = '{4'hF, 4'h0, 4'h1, 4'h1, 5'd8};
    vt[18] = '{4'h0, 4'h0, 4'h1, 4'h0, 5'd9};
    vt[19] = '{4'h0, 4'h0, 4'h0, 4'h0, 5'd9};

    // Reset state
    reset = 1'b1; req = '0; req_last = '0; req_d = '0; rd_req = 1'b1;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_read_flg", read_flg, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_write_flg", write_flg, 0);
    do_reset();

    // Round-robin table: 2-word bursts, order 0,1,2,3,0, two dead cycles
    for (int j = 0; j < 20; j++) begin
      req      = vt[j].req;
      req_last = vt[j].last;
      rd_req   = 1'b0;
      for (int i = 0; i < NREQ; i++) req_d[i*8 +: 8] = {4'(i), 4'(j)};
      @(negedge clk);
      check("rr_gnt", gnt, vt[j].gnt);
      check("rr_ack", ack, vt[j].ack);
      check("rr_write_flg", write_flg, |vt[j].ack);
      check("rr_level", level, vt[j].level);
      check("rr_empty", empty, vt[j].level == 5'd0);
      if (|vt[j].ack) begin
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (vt[j].gnt[i]) gi = i;
        check("rr_inp_d", inp_d, {4'(gi), 4'(j)});
      end
      tick();
    end

    // Burst cap: producer 2 streams 10 words, no req_last
    do_reset();
    exp_ack = 15'b110011110011110;
    w_exp = 0;
    req = 4'b0100;
    for (int j = 0; j < 15; j++) begin
      req_d = '0;
      req_d[2*8 +: 8] = 8'(w_exp);
      @(negedge clk);
      check("cap_ack", ack, exp_ack[j] ? 4'b0100 : 4'b0000);
      check("cap_gnt", gnt, exp_ack[j] ? 4'b0100 : 4'b0000);
      if (exp_ack[j]) begin
        check("cap_inp_d", inp_d, w_exp);
        w_exp++;
      end
      tick();
    end
    req = '0;
    tick(); tick(); tick();
    check("cap_level", level, 10);
    read_drain(10, 8'h00);

    // Empty read, then write 0..3 and read them back
    do_reset();
    rd_req = 1'b1;
    @(negedge clk);
    check("empty_read_flg", read_flg, 0);
    check("empty_flag", empty, 1);
    tick();
    rd_req = 1'b0;
    write_words(1, 4, 8'h00);
    tick(); tick();
    check("er_level4", level, 4);
    read_drain(4, 8'h00);
    check("er_level0", level, 0);
    check("er_empty", empty, 1);

    // Simultaneous read and write at level 5
    write_words(3, 5, 8'h40);
    tick(); tick();
    check("sim_level_pre", level, 5);
    req = 4'b1000; req_last = 4'b1000; req_d = '0; req_d[3*8 +: 8] = 8'h45;
    b = 0;
    @(negedge clk);
    while (gnt !== 4'b1000 && b < 20) begin
      tick();
      @(negedge clk);
      b++;
    end
    rd_req = 1'b1;
    #1;
    check("sim_write_flg", write_flg, 1);
    check("sim_read_flg", read_flg, 1);
    tick();
    rd_req = 1'b0; req = '0; req_last = '0;
    @(negedge clk);
    check("sim_level_post", level, 5);
    check("sim_rd_valid", rd_valid, 1);
    check("sim_out_d", out_d, 8'h40);
    tick(); tick();
    read_drain(5, 8'h41);

    // Full stall
    do_reset();
    write_words(0, 16, 8'h00);
    tick(); tick();
    check("full_level", level, 16);
    check("full_flag", full, 1);
    req = 4'b0001; req_last = 4'b0001; req_d = '0; req_d[7:0] = 8'hAA;
    b = 0;
    @(negedge clk);
    while (gnt !== 4'b0001 && b < 20) begin
      tick();
      @(negedge clk);
      b++;
    end
    for (int k = 0; k < 3; k++) begin
      check("stall_gnt", gnt, 4'b0001);
      check("stall_ack", ack, 0);
      check("stall_write_flg", write_flg, 0);
      tick();
      if (k < 2) @(negedge clk);
    end
    rd_req = 1'b1;
    @(negedge clk);
    check("fullrd_read_flg", read_flg, 1);
    check("fullrd_write_flg", write_flg, 0);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    check("freed_level", level, 15);
    check("freed_ack", ack, 4'b0001);
    check("freed_write_flg", write_flg, 1);
    check("freed_inp_d", inp_d, 8'hAA);
    check("freed_rd_valid", rd_valid, 1);
    check("freed_out_d", out_d, 8'h00);
    tick();
    req = '0; req_last = '0;
    @(negedge clk);
    check("refull_level", level, 16);
    tick();

    // Reset mid-burst: producer 1 granted with two words accepted
    do_reset();
    req = 4'b0010;
    tick(); tick(); tick();
    check("mid_pre_gnt", gnt, 4'b0010);
    check("mid_pre_level", level, 2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", empty, 1);
    req = 4'b0011;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("mid_post_gnt", gnt, 4'b0001);
    check("mid_post_ack", ack, 4'b0001);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_arb_ctrl.md
# fifo_arb_ctrl

Single-clock controller that shares the write port of the existing `fifo` among several producers and schedules its read port for one consumer. It sits directly in front of a `fifo` instance. It drives that instance's `write_flg`, `inp_d` and `read_flg` ports and tracks occupancy so producers and the consumer never overflow or underflow it. Both `inp_clk` and `out_clk` of the attached `fifo` are tied to this block's clock.

## Interface
Parameters:
- `NREQ`, 4: number of producers (≥2)
- `DW`, 8: data width; must match the attached `fifo`
- `DEPTH`, 16: `fifo` capacity in words (power of two)
- `MAX_BURST`, 4: maximum words per grant (≥1)

Ports:
- `inp_clk` in 1: the only clock
- `reset` in 1: asynchronous, active-high
- `req` in NREQ: producer i has a word to write
- `req_d` in NREQ*DW: producer i data in slice [i*DW +: DW]
- `req_last` in NREQ: current word is the producer's last of this burst
- `gnt` out NREQ: one-hot grant, registered
- `ack` out NREQ: word of producer i accepted this cycle
- `write_flg` out 1: to `fifo`
- `inp_d` out DW: to `fifo`
- `rd_req` in 1: consumer wants a word
- `read_flg` out 1: to `fifo`
- `rd_valid` out 1: `fifo` `out_d` holds a valid word this cycle
- `level` out log2(DEPTH)+1: words stored
- `full` out 1: `level == DEPTH`
- `empty` out 1: `level == 0`

## Operation
- Write FSM states are `IDLE`, `BURST` and `TURN`.
- `IDLE`: if any `req` is high, select a producer round-robin, starting the search at `last+1` mod NREQ. Load `gnt` one-hot, record `last`, clear `bcnt` and go to `BURST`. Otherwise stay in `IDLE`.
- `BURST`: `ack[g] = req[g] & gnt[g] & !full`. `write_flg = |ack`. `inp_d = req_d` slice of g; it is don't-care while `write_flg` is low.
  - Each ack increments `bcnt`.
  - Leave to `TURN` when an ack coincides with `req_last[g]`, or when an ack makes `bcnt == MAX_BURST`, or when `req[g]` is low.
  - While `full`, hold `gnt` and stall. The burst does not end on full.
- `TURN`: `gnt = 0` for one cycle, then `IDLE`. This guarantees fairness.
- Read: `read_flg = rd_req & !empty`. `rd_valid` is `read_flg` delayed by one cycle.
- Level update: `level <= level + write_flg - read_flg`. A simultaneous read and write leaves `level` unchanged.
- `full` and `empty` are decoded from registered `level`.
  - A read in a full cycle does not enable a write in that same cycle.
  - A write in an empty cycle does not enable a read in that same cycle.
- Reset, asynchronous at any time, including mid-burst:
  - State goes to `IDLE`.
  - `gnt`, `ack`, `write_flg`, `read_flg`, `rd_valid` and `level` go to 0. `empty` = 1, `full` = 0.
  - `last` = NREQ-1, so producer 0 wins first. `bcnt` = 0.
  - The attached `fifo` must be reset by the same signal.

## Timing
- Grant latency: a `req` seen in `IDLE` at edge k gives `gnt` high after edge k. The first ack and write are in that same cycle if `req` is still high and the `fifo` is not full.
- Throughput: up to MAX_BURST writes on consecutive cycles, then 2 dead cycles (`TURN`, `IDLE`) before the next grant.
- Read latency: `read_flg` in cycle n gives `rd_valid` and valid `out_d` in cycle n+1. Back-to-back reads are allowed.
- `write_flg`, `inp_d`, `ack` and `read_flg` are combinational from registered state and inputs. Everything else is registered.

## Structure
- Shared package `fifo_pkg`: state encoding for `IDLE`/`BURST`/`TURN`, the level-width function, and default DW/DEPTH constants also used by `fifo`.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are `req` and `last`; outputs are a one-hot grant and a valid flag.
- The top level holds the FSM, burst counter, level counter and read pipe register.

## Test plan
- Reset mid-burst: with producer 1 granted and `bcnt` = 2, assert `reset` asynchronously. Immediately `gnt` = 0, `level` = 0, `empty` = 1. After release, producer 0 wins first.
- Round-robin: `req` = 4'b1111 held, each producer sending 2 words with `req_last` on the 2nd. Grants go in order 0,1,2,3,0. There are exactly 2 dead cycles between bursts, and `level` reaches 8.
- Burst cap: producer 2 streams 10 words with no `req_last` and MAX_BURST = 4. Grants are 4 words, then `TURN`, then a re-grant. Data 0..9 is written in order.
- Full stall: fill to `level` = 16 with `rd_req` low. A further `req` keeps `gnt` high with `ack` = 0 and no `write_flg`. Raising `rd_req` frees a slot, and the write completes one cycle later.
- Empty read: `rd_req` high with the `fifo` empty gives `read_flg` = 0. Write 0x00..0x03, then read: `rd_valid` is high for 4 cycles with `out_d` = 0,1,2,3, and `level` returns to 0.
- Simultaneous: at `level` = 5, one write and one read in the same cycle leave `level` at 5.
